// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
// State encoding, opcodes and the address range helper.
package mem_pkg;

  localparam int WORD_W        = 32;
  localparam int DEFAULT_DEPTH = 512;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Full-width compare so upper address bits never alias into the array.
  function automatic logic addr_oor(
    input logic [WORD_W-1:0] a,
    input int                depth
  );
    return a >= WORD_W'(depth);
  endfunction

endpackage

// File: rtl/mem_responder_spram_32.sv
// Single-port synchronous RAM, DEPTH x 32.
// Write-enable port and a read-enabled output register.
module spram_32
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Array write and registered read; the read register holds when idle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR bus.
// Accepts one request, waits, accesses the RAM, pulses mem_done.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] Mdatain,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_err
);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  op_t               r_op;
  logic              r_oor;
  logic              r_conf;
  logic [WORD_W-1:0] r_mdatain;
  logic              r_done;
  logic              r_busy;
  logic              r_err;

  logic              w_idle;
  logic              w_req;
  logic              w_conf;
  logic              w_oor;
  logic              w_access;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [WORD_W-1:0] w_ram_rdata;

  // Unused encoding 2'b11 behaves as IDLE.
  assign w_idle = (r_state != WAIT) && (r_state != RESP);
  assign w_req  = mem_read | mem_write;
  assign w_conf = mem_read & mem_write;
  assign w_oor  = addr_oor(addr, DEPTH);

  assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);

  // The RAM is read at the accept edge so its output register is
  // ready by the access edge even with zero wait states. Nothing can
  // write the array in between because requests are serialized.
  assign w_ram_re = ~clr & w_idle & mem_read & ~mem_write & ~w_oor;

  assign w_ram_we = ~clr & w_access & (r_op == OP_WRITE) &
                    ~r_oor & ~r_conf;

  assign w_ram_addr = w_idle ? addr[ADDR_W-1:0] : r_addr;

  spram_32 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Request FSM, wait counter and registered bus outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_mdatain <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_done  <= 1'b1;
            r_state <= RESP;
            if (r_conf) begin
              r_err <= 1'b1;
            end else if (r_oor) begin
              r_err <= 1'b1;
              if (r_op == OP_READ) begin
                r_mdatain <= '0;
              end
            end else begin
              r_err <= 1'b0;
              if (r_op == OP_READ) begin
                r_mdatain <= w_ram_rdata;
              end
            end
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          if (w_req) begin
            r_addr  <= addr[ADDR_W-1:0];
            r_wdata <= wdata;
            r_op    <= mem_write ? OP_WRITE : OP_READ;
            r_conf  <= w_conf;
            r_oor   <= w_oor;
            r_cnt   <= 4'(WAIT_STATES);
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end
        end
      endcase
    end
  end

  assign Mdatain  = r_mdatain;
  assign mem_done = r_done;
  assign mem_busy = r_busy;
  assign mem_err  = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder, two instances
// (3 and 1 cycle access latency), directed plus random traffic.
module tb_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr [2];
  logic        rd  [2];
  logic        wr  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic [31:0] md  [2];
  logic        dn  [2];
  logic        bz  [2];
  logic        er  [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] mem_m [2][512];
  logic [31:0] md_m [2];
  int ws [2] = '{2, 0};

  mem_responder #(
    .DEPTH(512), .ADDR_W(9), .WAIT_STATES(2)
  ) u0 (
    .clk(clk), .clr(clr[0]),
    .mem_read(rd[0]), .mem_write(wr[0]),
    .addr(ad[0]), .wdata(wd[0]),
    .Mdatain(md[0]), .mem_done(dn[0]),
    .mem_busy(bz[0]), .mem_err(er[0])
  );

  mem_responder #(
    .DEPTH(512), .ADDR_W(9), .WAIT_STATES(0)
  ) u1 (
    .clk(clk), .clr(clr[1]),
    .mem_read(rd[1]), .mem_write(wr[1]),
    .addr(ad[1]), .wdata(wd[1]),
    .Mdatain(md[1]), .mem_done(dn[1]),
    .mem_busy(bz[1]), .mem_err(er[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic mon(input int s);
    exp_t e;
    int   sz;
    if (dn[s] !== 1'b1) return;
    sz = (s == 0) ? q0.size() : q1.size();
    chk($sformatf("u%0d done expected", s), 32'(sz > 0), 32'd1);
    if (sz == 0) return;
    if (s == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("u%0d mem_err", s), 32'(er[s]), 32'(e.err));
    chk($sformatf("u%0d Mdatain", s), md[s], e.data);
    chk($sformatf("u%0d latency", s), 32'(cyc), 32'(e.due));
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int s, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit noise);
    exp_t e;
    @(negedge clk);
    rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d;
    @(posedge clk); #1;
    e.due = cyc + 1 + ws[s];
    if (r && w) begin
      e.err = 1'b1;
    end else if (a >= 32'd512) begin
      e.err = 1'b1;
      if (r) md_m[s] = 32'd0;
    end else if (r) begin
      e.err = 1'b0;
      md_m[s] = mem_m[s][a[8:0]];
    end else begin
      e.err = 1'b0;
      mem_m[s][a[8:0]] = d;
    end
    e.data = md_m[s];
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
    rd[s] = 1'b0;
    wr[s] = noise;
    wd[s] = 32'h0000_0BAD;
    chk($sformatf("u%0d busy accept", s), 32'(bz[s]), 32'd1);
    for (int i = 0; i <= ws[s]; i++) begin
      @(posedge clk); #1;
      wr[s] = 1'b0;
      chk($sformatf("u%0d busy wait", s), 32'(bz[s]), 32'd1);
    end
    @(posedge clk); #1;
    chk($sformatf("u%0d busy idle", s), 32'(bz[s]), 32'd0);
  endtask

  task automatic abort_wr(input int s, input logic [31:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    wr[s] = 1'b1; ad[s] = a; wd[s] = d;
    @(posedge clk); #1;
    wr[s] = 1'b0;
    clr[s] = 1'b1;
    @(posedge clk); #1;
    clr[s] = 1'b0;
    md_m[s] = 32'd0;
    chk($sformatf("u%0d abort busy", s), 32'(bz[s]), 32'd0);
    chk($sformatf("u%0d abort done", s), 32'(dn[s]), 32'd0);
    chk($sformatf("u%0d abort Mdatain", s), md[s], 32'd0);
    chk($sformatf("u%0d abort err", s), 32'(er[s]), 32'd0);
    repeat (ws[s] + 3) @(posedge clk);
    #1;
  endtask

  task automatic rnd(input int s, input int n);
    int          p;
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      p = $urandom_range(0, 99);
      a = 32'($urandom_range(0, 31));
      d = $urandom;
      if (p < 5) begin
        issue(s, 1'b1, 1'b1, a, d, 1'b0);
      end else if (p < 15) begin
        a = (32'd1 << $urandom_range(9, 31)) | a;
        issue(s, p[0], ~p[0], a, d, 1'b0);
      end else if (p < 55) begin
        issue(s, 1'b1, 1'b0, a, d, 1'b0);
      end else begin
        issue(s, 1'b0, 1'b1, a, d, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: test did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      clr[s] = 1'b1; rd[s] = 1'b1; wr[s] = 1'b0;
      ad[s] = 32'd0; wd[s] = 32'd0; md_m[s] = 32'd0;
      for (int j = 0; j < 512; j++) mem_m[s][j] = 32'd0;
    end

    repeat (2) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("u%0d rst Mdatain", s), md[s], 32'd0);
        chk($sformatf("u%0d rst done", s), 32'(dn[s]), 32'd0);
        chk($sformatf("u%0d rst busy", s), 32'(bz[s]), 32'd0);
        chk($sformatf("u%0d rst err", s), 32'(er[s]), 32'd0);
      end
    end
    clr[0] = 1'b0; clr[1] = 1'b0;
    rd[1] = 1'b0;

    issue(0, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
    issue(0, 1'b1, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0005, 32'd0, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h8000_0010, 32'h0000_5555, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    abort_wr(0, 32'h0000_0020, 32'hCAFE_F00D);
    issue(0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
    rnd(0, 60);

    issue(1, 1'b0, 1'b1, 32'h0000_0030, 32'h1111_2222, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h0000_0030, 32'd0, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h0000_0030, 32'd0, 1'b1);
    abort_wr(1, 32'h0000_0020, 32'hCAFE_F00D);
    issue(1, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
    rnd(1, 40);

    repeat (5) @(posedge clk);
    #1;
    chk("u0 queue drained", 32'(q0.size()), 32'd0);
    chk("u1 queue drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
